// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller for any depth >= 2, with FWFT or registered read,
// sticky overflow/underflow flags and a high-water-mark monitor.
module sync_fifo_ctl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNTW  = $clog2(DEPTH + 1),
    parameter int FWFT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             rd_dat_vld,
    input  logic [CNTW-1:0]  cfg_afull,
    input  logic [CNTW-1:0]  cfg_aempty,
    input  logic             err_clr,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CNTW-1:0]  fifo_num,
    output logic [CNTW-1:0]  high_water,
    output logic             ovf,
    output logic             unf
);

    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CNTW-1:0] NUM_MAX  = CNTW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CNTW-1:0]  num_q;
    logic [CNTW-1:0]  num_d;
    logic [CNTW-1:0]  hw_q;
    logic             ovf_q;
    logic             unf_q;
    logic             wr_acc;
    logic             rd_acc;

    // Wrap by compare so non-power-of-two depths never alias.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full         = (num_q == NUM_MAX);
    assign empty        = (num_q == '0);
    assign almost_full  = (num_q >= cfg_afull);
    assign almost_empty = (num_q <= cfg_aempty);
    assign fifo_num     = num_q;
    assign high_water   = hw_q;
    assign ovf          = ovf_q;
    assign unf          = unf_q;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        num_d = num_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   num_d = num_q + 1'b1;
            2'b01:   num_d = num_q - 1'b1;
            default: num_d = num_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            num_q  <= '0;
            hw_q   <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            num_q <= num_d;
            // A set condition in the clear cycle must win.
            ovf_q <= (ovf_q & ~err_clr) | (wr_en & full);
            unf_q <= (unf_q & ~err_clr) | (rd_en & empty);
            if (err_clr || (num_d > hw_q)) begin
                hw_q <= num_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_dat     = empty ? '0 : mem[rd_ptr];
            assign rd_dat_vld = ~empty;
        end else begin : g_std
            logic [WIDTH-1:0] dat_q;
            logic             vld_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dat_q <= '0;
                    vld_q <= 1'b0;
                end else begin
                    vld_q <= rd_acc;
                    if (rd_acc) begin
                        dat_q <= mem[rd_ptr];
                    end
                end
            end

            assign rd_dat     = dat_q;
            assign rd_dat_vld = vld_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Directed bench: a standard-mode and an FWFT-mode FIFO, both DEPTH=5,
// driven by the same stimulus and checked against hand-computed vectors.
module tb_sync_fifo_ctl;

    localparam int W  = 8;
    localparam int D  = 5;
    localparam int CW = $clog2(D + 1);

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [W-1:0]  wr_dat;
    logic          rd_en;
    logic          err_clr;
    logic [CW-1:0] cfg_afull;
    logic [CW-1:0] cfg_aempty;

    logic [W-1:0]  s_dat, f_dat;
    logic          s_vld, f_vld;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [CW-1:0] s_num, s_hw, f_num, f_hw;

    int n_chk = 0;
    int n_err = 0;

    sync_fifo_ctl #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_dat(wr_dat),
        .rd_en(rd_en), .rd_dat(s_dat), .rd_dat_vld(s_vld),
        .cfg_afull(cfg_afull), .cfg_aempty(cfg_aempty),
        .err_clr(err_clr), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae),
        .fifo_num(s_num), .high_water(s_hw), .ovf(s_ovf), .unf(s_unf)
    );

    sync_fifo_ctl #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_dat(wr_dat),
        .rd_en(rd_en), .rd_dat(f_dat), .rd_dat_vld(f_vld),
        .cfg_afull(cfg_afull), .cfg_aempty(cfg_aempty),
        .err_clr(err_clr), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae),
        .fifo_num(f_num), .high_water(f_hw), .ovf(f_ovf), .unf(f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic       clr;
        logic [2:0] num;
        logic [5:0] flg;
        logic [2:0] hw;
        logic       svld;
        logic [7:0] sdat;
        logic       fvld;
        logic [7:0] fdat;
    } vec_t;

    vec_t vt[24];

    function automatic vec_t mk(input int r, we, wd, re, clr, n, f, hw,
                                input int sv, sd, fv, fd);
        vec_t v;
        v.rst  = r[0];
        v.we   = we[0];
        v.wd   = wd[7:0];
        v.re   = re[0];
        v.clr  = clr[0];
        v.num  = n[2:0];
        v.flg  = f[5:0];
        v.hw   = hw[2:0];
        v.svld = sv[0];
        v.sdat = sd[7:0];
        v.fvld = fv[0];
        v.fdat = fd[7:0];
        return v;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [7:0] wd,
                         input logic re, input logic clr);
        rst     = r;
        wr_en   = we;
        wr_dat  = wd;
        rd_en   = re;
        err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    logic [5:0] s_flg;
    assign s_flg = {s_full, s_empty, s_af, s_ae, s_ovf, s_unf};

    initial begin
        cfg_afull  = 3'd3;
        cfg_aempty = 3'd1;
        rst = 1'b1; wr_en = 1'b0; wr_dat = '0; rd_en = 1'b0; err_clr = 1'b0;

        // flags: full empty afull aempty ovf unf
        //         rst we wd     re clr num flg       hw sv sd     fv fd
        vt[0]  = mk(1, 0, 'h00, 0, 0, 0, 'b010100, 0, 0, 'h00, 0, 'h00);
        vt[1]  = mk(0, 1, 'h11, 0, 0, 1, 'b000100, 1, 0, 'h00, 1, 'h11);
        vt[2]  = mk(0, 1, 'h12, 0, 0, 2, 'b000000, 2, 0, 'h00, 1, 'h11);
        vt[3]  = mk(0, 1, 'h13, 0, 0, 3, 'b001000, 3, 0, 'h00, 1, 'h11);
        vt[4]  = mk(0, 1, 'h14, 0, 0, 4, 'b001000, 4, 0, 'h00, 1, 'h11);
        vt[5]  = mk(0, 1, 'h15, 0, 0, 5, 'b101000, 5, 0, 'h00, 1, 'h11);
        vt[6]  = mk(0, 1, 'h99, 1, 0, 4, 'b001010, 5, 1, 'h11, 1, 'h12);
        vt[7]  = mk(0, 0, 'h00, 1, 0, 3, 'b001010, 5, 1, 'h12, 1, 'h13);
        vt[8]  = mk(0, 0, 'h00, 1, 0, 2, 'b000010, 5, 1, 'h13, 1, 'h14);
        vt[9]  = mk(0, 0, 'h00, 1, 0, 1, 'b000110, 5, 1, 'h14, 1, 'h15);
        vt[10] = mk(0, 0, 'h00, 1, 0, 0, 'b010110, 5, 1, 'h15, 0, 'h00);
        vt[11] = mk(0, 0, 'h00, 1, 0, 0, 'b010111, 5, 0, 'h15, 0, 'h00);
        vt[12] = mk(0, 0, 'h00, 0, 1, 0, 'b010100, 0, 0, 'h15, 0, 'h00);
        vt[13] = mk(0, 0, 'h00, 1, 1, 0, 'b010101, 0, 0, 'h15, 0, 'h00);
        vt[14] = mk(0, 0, 'h00, 0, 1, 0, 'b010100, 0, 0, 'h15, 0, 'h00);
        vt[15] = mk(0, 1, 'h21, 1, 0, 1, 'b000101, 1, 0, 'h15, 1, 'h21);
        vt[16] = mk(0, 1, 'h22, 1, 1, 1, 'b000100, 1, 1, 'h21, 1, 'h22);
        vt[17] = mk(0, 1, 'h23, 0, 0, 2, 'b000000, 2, 0, 'h21, 1, 'h22);
        vt[18] = mk(0, 1, 'h24, 0, 0, 3, 'b001000, 3, 0, 'h21, 1, 'h22);
        vt[19] = mk(0, 1, 'h25, 0, 0, 4, 'b001000, 4, 0, 'h21, 1, 'h22);
        vt[20] = mk(0, 0, 'h00, 1, 0, 3, 'b001000, 4, 1, 'h22, 1, 'h23);
        vt[21] = mk(0, 0, 'h00, 1, 0, 2, 'b000000, 4, 1, 'h23, 1, 'h24);
        vt[22] = mk(0, 0, 'h00, 1, 0, 1, 'b000100, 4, 1, 'h24, 1, 'h25);
        vt[23] = mk(0, 0, 'h00, 0, 1, 1, 'b000100, 1, 0, 'h24, 1, 'h25);

        for (int i = 0; i < 24; i++) begin
            drive(vt[i].rst, vt[i].we, vt[i].wd, vt[i].re, vt[i].clr);
            chk("num",      i, 32'(s_num), 32'(vt[i].num));
            chk("flags",    i, 32'(s_flg), 32'(vt[i].flg));
            chk("hw",       i, 32'(s_hw),  32'(vt[i].hw));
            chk("std_vld",  i, 32'(s_vld), 32'(vt[i].svld));
            chk("std_dat",  i, 32'(s_dat), 32'(vt[i].sdat));
            chk("fwft_vld", i, 32'(f_vld), 32'(vt[i].fvld));
            chk("fwft_dat", i, 32'(f_dat), 32'(vt[i].fdat));
            chk("fwft_num", i, 32'(f_num), 32'(vt[i].num));
        end

        // Streaming through one held entry: pointers wrap several times.
        for (int i = 0; i < 23; i++) begin
            logic [7:0] d;
            logic [7:0] prev;
            d    = 8'h30 + 8'(i);
            prev = (i == 0) ? 8'h25 : d - 8'h01;
            drive(1'b0, 1'b1, d, 1'b1, 1'b0);
            chk("wrap_num",  i, 32'(s_num), 32'd1);
            chk("wrap_svld", i, 32'(s_vld), 32'd1);
            chk("wrap_sdat", i, 32'(s_dat), 32'(prev));
            chk("wrap_fdat", i, 32'(f_dat), 32'(d));
        end

        drive(1'b0, 1'b1, 8'h60, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h61, 1'b0, 1'b0);
        chk("pre_rst_num", 0, 32'(s_num), 32'd3);
        chk("pre_rst_fdat", 0, 32'(f_dat), 32'h46);

        // Reset beats a simultaneous write and read.
        drive(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
        chk("rst_num",   0, 32'(s_num), 32'd0);
        chk("rst_flags", 0, 32'(s_flg), 32'b010100);
        chk("rst_hw",    0, 32'(s_hw),  32'd0);
        chk("rst_svld",  0, 32'(s_vld), 32'd0);
        chk("rst_sdat",  0, 32'(s_dat), 32'h00);
        chk("rst_fvld",  0, 32'(f_vld), 32'd0);
        chk("rst_fdat",  0, 32'(f_dat), 32'h00);

        drive(1'b0, 1'b1, 8'h42, 1'b0, 1'b0);
        chk("post_num",  0, 32'(s_num), 32'd1);
        chk("post_fvld", 0, 32'(f_vld), 32'd1);
        chk("post_fdat", 0, 32'(f_dat), 32'h42);
        chk("post_svld", 0, 32'(s_vld), 32'd0);

        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rd_svld",  0, 32'(s_vld),   32'd1);
        chk("post_rd_sdat",  0, 32'(s_dat),   32'h42);
        chk("post_rd_empty", 0, 32'(s_empty), 32'd1);
        chk("post_rd_fvld",  0, 32'(f_vld),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
